clock_set_ctrl: RTL

Mode/sequencing controller for the seconds/minutes clock counter datapath. Generates the 1 Hz count enable from `clk`, decodes two debounced user buttons into a RUN / SET_MIN / SET_SEC state machine, and holds edit copies of the time. On exit from set mode it issues a one-cycle parallel load to the counter. It sits between the button debouncers and the counter, and feeds the display mux.

---
 rtl/clock_pkg.sv | 10 +
 rtl/clock_set_ctrl_btn_edge.sv | 11 +
 rtl/clock_set_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared mode enum, field limits and time type for the clock controller
package clock_pkg;
  typedef enum logic [1:0] {RUN = 2'b00, SET_MIN = 2'b01, SET_SEC = 2'b10} clk_mode_e;
  localparam int MAX_SEC = 59;
  localparam int MAX_MIN = 59;
  typedef logic [5:0] time6_t;
  function automatic time6_t wrap_inc(input time6_t v, input int max_v);
    return (int'(v) == max_v) ? '0 : v + 6'd1;
  endfunction
endpackage

// File: rtl/clock_set_ctrl_btn_edge.sv
// btn_edge: rising-edge detector (clk, rst, level -> rise), one pulse per press
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk) prev <= rst ? 1'b0 : level;
  assign rise = level & ~prev;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: 1 Hz tick, RUN/SET_MIN/SET_SEC button FSM, edit copies and load strobe (clk rst mode_btn inc_btn cur_sec cur_min -> tick_en load_en load_sec load_min disp_sec disp_min mode blank_sec blank_min); CLKCTRL_BLINK_EN enables field blinking
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter  int TICKS_PER_SEC = 50_000_000,
  localparam int CNT_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [5:0] cur_sec,
  input  logic [5:0] cur_min,
  output logic       tick_en,
  output logic       load_en,
  output logic [5:0] load_sec,
  output logic [5:0] load_min,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic [1:0] mode,
  output logic       blank_sec,
  output logic       blank_min
);
  clk_mode_e state;
  logic [CNT_W-1:0] presc;
  time6_t edit_sec, edit_min;
  logic mode_e, inc_e, last;
  btn_edge u_mode (.clk(clk), .rst(rst), .level(mode_btn), .rise(mode_e));
  btn_edge u_inc  (.clk(clk), .rst(rst), .level(inc_btn),  .rise(inc_e));
  assign last = presc == CNT_W'(TICKS_PER_SEC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      presc    <= '0;
      edit_sec <= '0;
      edit_min <= '0;
      tick_en  <= 1'b0;
      load_en  <= 1'b0;
      load_sec <= '0;
      load_min <= '0;
    end else begin
      presc   <= (last || (mode_e && state == SET_SEC)) ? '0 : presc + CNT_W'(1);
      tick_en <= last && state == RUN && !mode_e;
      load_en <= mode_e && state == SET_SEC;
      if (mode_e) begin
        state <= state == RUN ? SET_MIN : state == SET_MIN ? SET_SEC : RUN;
        if (state == RUN) begin
          edit_min <= cur_min;
          edit_sec <= cur_sec;
        end
        if (state == SET_SEC) begin
          load_min <= edit_min;
          load_sec <= edit_sec;
        end
      end else if (inc_e) begin
        if (state == SET_MIN) edit_min <= wrap_inc(edit_min, MAX_MIN);
        if (state == SET_SEC) edit_sec <= wrap_inc(edit_sec, MAX_SEC);
      end
    end
  end
`ifdef CLKCTRL_BLINK_EN
  logic half;
  assign half = presc >= CNT_W'(TICKS_PER_SEC / 2);
  always_ff @(posedge clk) begin
    blank_min <= !rst && state == SET_MIN && half;
    blank_sec <= !rst && state == SET_SEC && half;
  end
`else
  assign blank_min = 1'b0;
  assign blank_sec = 1'b0;
`endif
  assign mode     = state;
  assign disp_sec = state == RUN ? cur_sec : edit_sec;
  assign disp_min = state == RUN ? cur_min : edit_min;
endmodule
